// File: rtl/mem_fetch_pkg.sv
// Shared definitions for the memory fetch unit: FSM states, IR field
// positions and the reset/NOP instruction encoding.
package mem_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  // IR field bit positions (MIPS-style encoding)
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JADDR_MSB  = 25;
  localparam int JADDR_LSB  = 0;

  // sll $0,$0,0 -- the value IR holds out of reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/mem_word_array.sv
// Unified word memory: synchronous write port, asynchronous read port,
// both indexed by word.
module mem_word_array
  import mem_fetch_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Write port; storage keeps its contents across reset.
  // NOTE: the array has no reset branch so it maps onto RAM macros; a reset
  // loop over every word would force it into flops.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_fetch_unit.sv
// Memory-side companion of the multi-cycle CPU controller: owns the word
// memory, IR and MDR, and decodes IR into instruction fields.
// Optional feature macro: MEMIF_PERF_CNT_EN enables the RdCount/StallCount
// performance counters; when undefined both outputs are tied to zero.
module mem_fetch_unit
  import mem_fetch_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        IorD,
  input  logic        IRWrite,
  input  logic [31:0] PC,
  input  logic [31:0] ALUOut,
  input  logic [31:0] WriteData,
  output logic        MemBusy,
  output logic        AddrErr,
  output logic [31:0] Instruction,
  output logic [5:0]  OpCode,
  output logic [5:0]  Funct,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [15:0] Imm16,
  output logic [25:0] JAddr,
  output logic [31:0] MDR,
  output logic [31:0] RdCount,
  output logic [31:0] StallCount
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

  logic [31:0]   addr;
  logic [AW-1:0] req_idx;
  logic          addr_ok;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          irw_q, irw_d;
  logic          mem_we, ir_load, mdr_load, err_d;
  logic [31:0]   ir_q, mdr_q, rd_data;
  logic          addr_err_q;

  assign addr    = IorD ? ALUOut : PC;
  assign req_idx = addr[AW+1:2];
  assign addr_ok = (addr[1:0] == 2'b00) && (addr[31:AW+2] == '0);

  mem_word_array #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (req_idx),
    .wdata (WriteData),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  // Next-state logic: accept requests in IDLE, count down the read latency in READ.
  // NOTE: every signal gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    irw_d    = irw_q;
    mem_we   = 1'b0;
    ir_load  = 1'b0;
    mdr_load = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MemWrite || MemRead) begin
          if (!addr_ok) begin
            err_d = 1'b1;
          end else if (MemWrite) begin
            mem_we = 1'b1;                 // write wins; a concurrent read is dropped
          end else begin
            idx_d   = req_idx;
            irw_d   = IRWrite;
            cnt_d   = CNT_INIT;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == 4'd0) begin
          ir_load  = irw_q;
          mdr_load = !irw_q;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latency counter, latched request, IR/MDR and error pulse registers.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= '0;
      irw_q      <= 1'b0;
      ir_q       <= NOP_INSTR;
      mdr_q      <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      irw_q      <= irw_d;
      addr_err_q <= err_d;
      if (ir_load)  ir_q  <= rd_data;
      if (mdr_load) mdr_q <= rd_data;
    end
  end

  assign MemBusy     = (state_q == READ);
  assign AddrErr     = addr_err_q;
  assign Instruction = ir_q;
  assign MDR         = mdr_q;
  assign OpCode      = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign Rs          = ir_q[RS_MSB:RS_LSB];
  assign Rt          = ir_q[RT_MSB:RT_LSB];
  assign Rd          = ir_q[RD_MSB:RD_LSB];
  assign Shamt       = ir_q[SHAMT_MSB:SHAMT_LSB];
  assign Funct       = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign Imm16       = ir_q[IMM_MSB:IMM_LSB];
  assign JAddr       = ir_q[JADDR_MSB:JADDR_LSB];

`ifdef MEMIF_PERF_CNT_EN
  logic        rd_accept;
  logic [31:0] rd_cnt_q, stall_cnt_q;

  assign rd_accept = (state_q == IDLE) && MemRead && !MemWrite && addr_ok;

  // Performance counters: accepted reads and busy cycles, wrapping at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (rd_accept)         rd_cnt_q    <= rd_cnt_q + 32'd1;
      if (state_q == READ)   stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign RdCount    = rd_cnt_q;
  assign StallCount = stall_cnt_q;
`else
  assign RdCount    = 32'd0;
  assign StallCount = 32'd0;
`endif

endmodule
